instr_fetch_unit: RTL



---
 rtl/mips_pkg.sv | 21 ++
 rtl/ifu_skid_reg.sv | 43 ++++
 rtl/instr_fetch_unit.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: fetch FSM states and word constants.
package mips_pkg;

  localparam int unsigned INSTR_W = 32;

  localparam logic [INSTR_W-1:0] PC_INC    = 32'd4;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    IFU_IDLE,
    IFU_REQ,
    IFU_WAIT,
    IFU_HOLD
  } ifu_state_e;

  // Clear the byte-offset bits so every fetch address is word aligned.
  function automatic logic [INSTR_W-1:0] word_align(input logic [INSTR_W-1:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/ifu_skid_reg.sv
// Skid holding register: parks one fetched {pc+4, instr} pair while decode stalls.
module ifu_skid_reg #(
  parameter int unsigned Width = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o,
  output logic             valid_o
);

  logic [Width-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  // Clear wins over load so a redirect always empties the slot.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      data_d  = data_i;
      valid_d = 1'b1;
    end
  end

  // Holding register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one request outstanding to instruction
// memory and hands one instruction plus its PC+4 to decode. Branch/jump redirects flush
// stale fetches; a decode stall parks a returning word in the skid register.
// Optional build macro IFU_PERF_CNT_EN adds fetch/stall/flush performance counters.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [INSTR_W-1:0] NOP_WORD = NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [INSTR_W-1:0] imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [INSTR_W-1:0] branch_target,
  input  logic               jump,
  input  logic [INSTR_W-1:0] jump_target,
  output logic [INSTR_W-1:0] instr_out,
  output logic [INSTR_W-1:0] pc_plus4_out,
  output logic               instr_valid
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_count,
  output logic [31:0]        stall_cycles,
  output logic [15:0]        flush_count
`endif
);

  localparam int unsigned SkidW = 2 * INSTR_W;

  ifu_state_e         state_q, state_d;
  logic [INSTR_W-1:0] pc_q, pc_d, pc_inc;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [INSTR_W-1:0] pc4_q, pc4_d;
  logic               valid_q, valid_d;
  logic               kill_q, kill_d;
  logic               req_q, req_d;

  logic               redirect;
  logic [INSTR_W-1:0] redirect_pc;

  logic               skid_load, skid_clear, skid_valid;
  logic [SkidW-1:0]   skid_data;

  assign pc_inc      = pc_q + PC_INC;
  assign redirect    = branch_taken | jump;
  assign redirect_pc = word_align(branch_taken ? branch_target : jump_target);

  ifu_skid_reg #(
    .Width (SkidW)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .data_i  ({pc_inc, imem_rdata}),
    .data_o  (skid_data),
    .valid_o (skid_valid)
  );

  // Next-state logic: consumption first, then FSM loads, then redirect overrides all.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc4_d      = pc4_q;
    valid_d    = valid_q;
    kill_d     = kill_q;
    skid_load  = 1'b0;
    skid_clear = 1'b0;

    // Decode took the held instruction this cycle.
    if (valid_q && !stall) begin
      valid_d = 1'b0;
      instr_d = NOP_WORD;
    end

    if (redirect) begin
      pc_d       = redirect_pc;
      valid_d    = 1'b0;
      instr_d    = NOP_WORD;
      skid_clear = 1'b1;
      unique case (state_q)
        IFU_IDLE: state_d = IFU_REQ;
        IFU_REQ: begin
          // An accepted request still owes us one rvalid, which must be dropped.
          if (imem_ready) begin
            state_d = IFU_WAIT;
            kill_d  = 1'b1;
          end
        end
        IFU_WAIT: begin
          if (imem_rvalid) begin
            state_d = IFU_REQ;
            kill_d  = 1'b0;
          end else begin
            kill_d = 1'b1;
          end
        end
        IFU_HOLD: state_d = IFU_REQ;
        default:  state_d = IFU_IDLE;
      endcase
    end else begin
      unique case (state_q)
        IFU_IDLE: state_d = IFU_REQ;
        IFU_REQ: begin
          if (imem_ready) state_d = IFU_WAIT;
        end
        IFU_WAIT: begin
          if (imem_rvalid) begin
            if (kill_q) begin
              kill_d  = 1'b0;
              state_d = IFU_REQ;
            end else if (!valid_q || !stall) begin
              instr_d = imem_rdata;
              pc4_d   = pc_inc;
              valid_d = 1'b1;
              pc_d    = pc_inc;
              state_d = IFU_REQ;
            end else begin
              skid_load = 1'b1;
              state_d   = IFU_HOLD;
            end
          end
        end
        IFU_HOLD: begin
          if (!stall && skid_valid) begin
            instr_d    = skid_data[INSTR_W-1:0];
            pc4_d      = skid_data[SkidW-1:INSTR_W];
            pc_d       = skid_data[SkidW-1:INSTR_W];
            valid_d    = 1'b1;
            skid_clear = 1'b1;
            state_d    = IFU_REQ;
          end
        end
        default: state_d = IFU_IDLE;
      endcase
    end

    req_d = (state_d == IFU_REQ);
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IFU_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP_WORD;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      kill_q  <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      kill_q  <= kill_d;
      req_q   <= req_d;
    end
  end

  assign imem_req     = req_q;
  assign imem_addr    = pc_q;
  assign instr_out    = instr_q;
  assign pc_plus4_out = pc4_q;
  assign instr_valid  = valid_q;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_count_q, stall_cycles_q;
  logic [15:0] flush_count_q;
  logic        out_load;

  assign out_load = !redirect &&
                    ((state_q == IFU_WAIT && imem_rvalid && !kill_q && (!valid_q || !stall)) ||
                     (state_q == IFU_HOLD && !stall && skid_valid));

  // Free-running wrap-around performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count_q  <= '0;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (out_load)          fetch_count_q  <= fetch_count_q + 32'd1;
      if (stall && valid_q)  stall_cycles_q <= stall_cycles_q + 32'd1;
      if (redirect)          flush_count_q  <= flush_count_q + 16'd1;
    end
  end

  assign fetch_count  = fetch_count_q;
  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule
